bike_session_ctrl: RTL and testbench

Workout-session sequencer for the bike motor drive. It runs a session as warm-up ramp, timed run and cool-down ramp, with a latched fault stop. It turns a target speed level (from the upstream BMI classifier) and rider up/down buttons into a ramped speed_level and a duty word. That duty word feeds the PWM/DC-motor stage. It also drives fault_out and the increase/decrease LEDs.

---
 rtl/bike_pkg.sv | 16 +
 rtl/bike_tick_gen.sv | 16 +
 rtl/bike_session_ctrl.sv | 122 ++++++++++++
 tb/tb_bike_session_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bike_pkg.sv
// bike_pkg: shared state encoding, level/duty widths and speed defaults for the bike session controller
package bike_pkg;
  localparam int LVL_W = 4;
  localparam int DUTY_W = 8;
  localparam int DEF_SPEED_MIN = 1;
  localparam int DEF_SPEED_MAX = 10;
  localparam int DEF_DUTY_STEP = 25;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WARMUP   = 3'd1,
    RUN      = 3'd2,
    COOLDOWN = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } state_t;
endpackage

// File: rtl/bike_tick_gen.sv
// bike_tick_gen: step-tick prescaler, tick high on the terminal count, with synchronous clear
module bike_tick_gen #(
  parameter int TICK_DIV = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (!reset || clr || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/bike_session_ctrl.sv
// bike_session_ctrl: warm-up / run / cool-down speed sequencer with latched fault stop
module bike_session_ctrl
  import bike_pkg::*;
#(
  parameter int TICK_DIV   = 5000,
  parameter int RAMP_TICKS = 4,
  parameter int RUN_TICKS  = 600,
  parameter int SPEED_MIN  = DEF_SPEED_MIN,
  parameter int SPEED_MAX  = DEF_SPEED_MAX,
  parameter int DUTY_STEP  = DEF_DUTY_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              fault_in,
  input  logic              fault_ack,
  input  logic [LVL_W-1:0]  target_level,
  input  logic              adj_up,
  input  logic              adj_down,
  output logic [LVL_W-1:0]  speed_level,
  output logic [DUTY_W-1:0] duty,
  output logic              motor_en,
  output logic              fault_out,
  output logic [1:0]        leds,
  output logic [2:0]        state,
  output logic              session_done
);
  localparam int RW = RAMP_TICKS > 1 ? $clog2(RAMP_TICKS) : 1;
  localparam int NW = $clog2(RUN_TICKS + 1);
  localparam logic [LVL_W-1:0] LMIN = LVL_W'(SPEED_MIN);
  localparam logic [LVL_W-1:0] LMAX = LVL_W'(SPEED_MAX);
  state_t st, st_n;
  logic [LVL_W-1:0] lvl, lvl_n, tgt, tgt_n, toward;
  logic [RW-1:0] ramp, ramp_n;
  logic [NW-1:0] run, run_n;
  logic tick, go, step, adj;
  assign go = st == IDLE && start && !fault_in;
  assign step = tick && ramp == RW'(RAMP_TICKS - 1);
  assign adj = (st == WARMUP || st == RUN) && (adj_up ^ adj_down);
  assign speed_level = lvl;
  assign state = st;
  bike_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .clr(go),
    .tick(tick)
  );
  always_comb begin
    st_n = st;
    tgt_n = adj ? (adj_up ? (tgt == LMAX ? tgt : tgt + 1'b1) : (tgt == LMIN ? tgt : tgt - 1'b1)) : tgt;
    toward = lvl < tgt_n ? lvl + 1'b1 : (lvl > tgt_n ? lvl - 1'b1 : lvl);
    lvl_n = lvl;
    ramp_n = step ? '0 : ramp + RW'(tick);
    run_n = run;
    case (st)
      IDLE: if (go) begin
        st_n = WARMUP;
        lvl_n = '0;
        ramp_n = '0;
        tgt_n = target_level < LMIN ? LMIN : (target_level > LMAX ? LMAX : target_level);
      end
      // fault beats stop, stop beats tick and run timeout
      WARMUP, RUN, COOLDOWN:
        if (fault_in) begin
          st_n = FAULT;
          lvl_n = '0;
        end else if (stop && st != COOLDOWN) begin
          st_n = COOLDOWN;
          ramp_n = '0;
        end else if (st == WARMUP) begin
          lvl_n = step ? toward : lvl;
          if (lvl_n == tgt_n) begin
            st_n = RUN;
            run_n = '0;
            ramp_n = '0;
          end
        end else if (st == RUN) begin
          run_n = run + NW'(tick);
          if (tick && run_n == NW'(RUN_TICKS)) begin
            st_n = COOLDOWN;
            ramp_n = '0;
          end else lvl_n = step ? toward : lvl;
        end else begin
          lvl_n = step && lvl != '0 ? lvl - 1'b1 : lvl;
          st_n = lvl_n == '0 ? DONE : COOLDOWN;
        end
      DONE: st_n = IDLE;
      FAULT: st_n = fault_ack && !fault_in ? IDLE : FAULT;
      default: begin
        st_n = IDLE;
        lvl_n = '0;
      end
    endcase
  end
  // outputs are registered from the next state/level so they move on the same edge
  always_ff @(posedge clk)
    if (!reset) begin
      st <= IDLE;
      lvl <= '0;
      tgt <= '0;
      ramp <= '0;
      run <= '0;
      duty <= '0;
      motor_en <= 1'b0;
      fault_out <= 1'b0;
      leds <= '0;
      session_done <= 1'b0;
    end else begin
      st <= st_n;
      lvl <= lvl_n;
      tgt <= tgt_n;
      ramp <= ramp_n;
      run <= run_n;
      duty <= DUTY_W'(int'(lvl_n) * DUTY_STEP);
      motor_en <= st_n == WARMUP || st_n == RUN || st_n == COOLDOWN;
      fault_out <= st_n == FAULT;
      leds <= {lvl_n < tgt_n && (st_n == WARMUP || st_n == RUN),
               (lvl_n > tgt_n && st_n == RUN) || (lvl_n != '0 && st_n == COOLDOWN)};
      session_done <= st_n == DONE;
    end
endmodule

// File: tb/tb_bike_session_ctrl.sv
// tb_bike_session_ctrl: scenario tasks plus randomized run against a cycle-count reference model
module tb_bike_session_ctrl;
  localparam int TD = 4, RT = 2, RUNT = 10;
  logic clk = 0, reset = 0, start = 0, stop = 0, fault_in = 0, fault_ack = 0, adj_up = 0, adj_down = 0;
  logic [3:0] target_level = 0;
  logic [3:0] speed_level;
  logic [7:0] duty;
  logic motor_en, fault_out, session_done;
  logic [1:0] leds;
  logic [2:0] state;
  logic [19:0] dvec;
  int n_tests = 0, n_fail = 0;
  int m_st = 0, m_lvl = 0, m_tgt = 0, m_since = 0, m_pt = 0, m_rt = 0;
  bike_session_ctrl #(.TICK_DIV(TD), .RAMP_TICKS(RT), .RUN_TICKS(RUNT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .fault_in(fault_in),
    .fault_ack(fault_ack), .target_level(target_level), .adj_up(adj_up), .adj_down(adj_down),
    .speed_level(speed_level), .duty(duty), .motor_en(motor_en), .fault_out(fault_out),
    .leds(leds), .state(state), .session_done(session_done)
  );
  assign dvec = {state, speed_level, duty, motor_en, fault_out, leds, session_done};
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  // Reference: ticks are every TD-th edge since start; phases count ticks since their own entry.
  task automatic model_edge();
    bit tick, step;
    int tl;
    if (!reset) begin
      m_st = 0; m_lvl = 0; m_tgt = 0; m_since = 0; m_pt = 0; m_rt = 0;
      return;
    end
    m_since++;
    tick = (m_since % TD) == 0;
    if ((m_st == 1 || m_st == 2) && adj_up != adj_down)
      m_tgt = adj_up ? (m_tgt < 10 ? m_tgt + 1 : 10) : (m_tgt > 1 ? m_tgt - 1 : 1);
    step = 0;
    if (tick && m_st >= 1 && m_st <= 3) begin
      m_pt++;
      step = (m_pt % RT) == 0;
    end
    case (m_st)
      0: if (start && !fault_in) begin
        tl = int'(target_level);
        m_st = 1; m_lvl = 0; m_since = 0; m_pt = 0;
        m_tgt = tl < 1 ? 1 : (tl > 10 ? 10 : tl);
      end
      1, 2, 3: begin
        if (fault_in) begin
          m_st = 5; m_lvl = 0;
        end else if (stop && m_st != 3) begin
          m_st = 3; m_pt = 0;
        end else if (m_st == 1) begin
          if (step) m_lvl += (m_lvl < m_tgt) ? 1 : ((m_lvl > m_tgt) ? -1 : 0);
          if (m_lvl == m_tgt) begin m_st = 2; m_rt = 0; m_pt = 0; end
        end else if (m_st == 2) begin
          if (tick) begin
            m_rt++;
            if (m_rt == RUNT) begin m_st = 3; m_pt = 0; end
            else if (step) m_lvl += (m_lvl < m_tgt) ? 1 : ((m_lvl > m_tgt) ? -1 : 0);
          end
        end else begin
          if (step && m_lvl > 0) m_lvl--;
          if (m_lvl == 0) m_st = 4;
        end
      end
      4: m_st = 0;
      5: if (fault_ack && !fault_in) m_st = 0;
      default: m_st = 0;
    endcase
  endtask
  function automatic logic [19:0] mvec();
    logic [1:0] l;
    l[1] = m_lvl < m_tgt && (m_st == 1 || m_st == 2);
    l[0] = (m_lvl > m_tgt && m_st == 2) || (m_lvl != 0 && m_st == 3);
    return {3'(m_st), 4'(m_lvl), 8'(m_lvl * 25), m_st >= 1 && m_st <= 3, m_st == 5, l, m_st == 4};
  endfunction
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    start = 0; stop = 0; fault_ack = 0; adj_up = 0; adj_down = 0;
  endtask
  task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      cyc();
      ok = state == s;
    end
  endtask
  task automatic test_reset();
    reset = 0;
    cyc(); cyc();
    n_tests++;
    if (dvec !== 20'd0) begin n_fail++; $display("FAIL reset_outputs: got %h, expected 0", dvec); end
    reset = 1;
    cyc();
    n_tests++;
    if (dvec !== mvec()) begin n_fail++; $display("FAIL reset_release: got %h, expected %h", dvec, mvec()); end
  endtask
  task automatic run_normal(input string tag);
    int t1 = -1, t2 = -1, t3 = -1, trun = -1, tcool = -1, tc2 = -1, tdone = -1, tidle = -1, ndone = 0, d3 = -1;
    target_level = 3; start = 1;
    cyc();
    for (int i = 1; i <= 100; i++) begin
      cyc();
      n_tests++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL %s_trace@%0d: got %h, expected %h", tag, i, dvec, mvec()); end
      if (t1 < 0 && speed_level == 1) t1 = i;
      if (t2 < 0 && speed_level == 2) t2 = i;
      if (t3 < 0 && speed_level == 3) begin t3 = i; d3 = int'(duty); end
      if (trun < 0 && state == 2) trun = i;
      if (tcool < 0 && state == 3) tcool = i;
      if (tc2 < 0 && state == 3 && speed_level == 2) tc2 = i;
      if (session_done) begin ndone++; if (tdone < 0) tdone = i; end
      if (tidle < 0 && tdone >= 0 && state == 0) tidle = i;
    end
    n_tests++; if (t1 != 8) begin n_fail++; $display("FAIL %s_lvl1_time: got %0d, expected 8", tag, t1); end
    n_tests++; if (t2 != 16) begin n_fail++; $display("FAIL %s_lvl2_time: got %0d, expected 16", tag, t2); end
    n_tests++; if (t3 != 24 || d3 != 75) begin n_fail++; $display("FAIL %s_lvl3: got t=%0d duty=%0d, expected t=24 duty=75", tag, t3, d3); end
    n_tests++; if (trun != 24 || tcool != 64) begin n_fail++; $display("FAIL %s_run_window: got %0d..%0d, expected 24..64", tag, trun, tcool); end
    n_tests++; if (tc2 != 72) begin n_fail++; $display("FAIL %s_cool_lvl2: got %0d, expected 72", tag, tc2); end
    n_tests++; if (tdone != 88 || ndone != 1) begin n_fail++; $display("FAIL %s_done: got t=%0d n=%0d, expected t=88 n=1", tag, tdone, ndone); end
    n_tests++; if (tidle != 89) begin n_fail++; $display("FAIL %s_idle_time: got %0d, expected 89", tag, tidle); end
  endtask
  task automatic test_clamp();
    bit ok;
    target_level = 0; start = 1;
    cyc();
    repeat (8) cyc();
    n_tests++;
    if (speed_level !== 4'd1 || state !== 3'd2) begin n_fail++; $display("FAIL clamp_low: got lvl=%0d st=%0d, expected lvl=1 st=2", speed_level, state); end
    stop = 1;
    wait_state(3'd0, 100, ok);
    target_level = 15; start = 1;
    cyc();
    wait_state(3'd2, 200, ok);
    n_tests++;
    if (!ok || speed_level !== 4'd10 || duty !== 8'd250) begin n_fail++; $display("FAIL clamp_high: got lvl=%0d duty=%0d, expected lvl=10 duty=250", speed_level, duty); end
    adj_up = 1;
    cyc();
    repeat (8) cyc();
    n_tests++;
    if (speed_level !== 4'd10 || leds !== 2'b00) begin n_fail++; $display("FAIL clamp_adj_up: got lvl=%0d leds=%b, expected lvl=10 leds=00", speed_level, leds); end
    stop = 1;
    wait_state(3'd0, 300, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL clamp_drain: got state=%0d, expected 0", state); end
  endtask
  task automatic test_fault();
    bit ok;
    target_level = 3; start = 1;
    cyc();
    wait_state(3'd2, 200, ok);
    fault_in = 1;
    cyc();
    n_tests++;
    if ({state, speed_level, duty, motor_en, fault_out} !== {3'd5, 4'd0, 8'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL fault_entry: got %h, expected %h", {state, speed_level, duty, motor_en, fault_out}, {3'd5, 4'd0, 8'd0, 1'b0, 1'b1});
    end
    fault_ack = 1;
    cyc();
    n_tests++;
    if (state !== 3'd5) begin n_fail++; $display("FAIL fault_ack_held: got %0d, expected 5", state); end
    fault_in = 0;
    cyc(); cyc();
    n_tests++;
    if (state !== 3'd5 || fault_out !== 1'b1) begin n_fail++; $display("FAIL fault_latched: got st=%0d f=%b, expected st=5 f=1", state, fault_out); end
    fault_ack = 1;
    cyc();
    n_tests++;
    if (state !== 3'd0 || fault_out !== 1'b0 || dvec !== mvec()) begin n_fail++; $display("FAIL fault_clear: got %h, expected %h", dvec, mvec()); end
  endtask
  task automatic test_coincident();
    bit ok;
    target_level = 3; start = 1;
    cyc();
    wait_state(3'd2, 200, ok);
    stop = 1; fault_in = 1;
    cyc();
    n_tests++;
    if (state !== 3'd5) begin n_fail++; $display("FAIL stop_and_fault: got %0d, expected 5", state); end
    fault_in = 0; fault_ack = 1;
    cyc();
    target_level = 3; start = 1;
    cyc();
    wait_state(3'd2, 200, ok);
    adj_up = 1; adj_down = 1;
    cyc();
    repeat (8) cyc();
    n_tests++;
    if (speed_level !== 4'd3 || leds !== 2'b00) begin n_fail++; $display("FAIL adj_both: got lvl=%0d leds=%b, expected lvl=3 leds=00", speed_level, leds); end
    adj_up = 1;
    cyc();
    n_tests++;
    if (leds !== 2'b10) begin n_fail++; $display("FAIL adj_up_run: got leds=%b, expected 10", leds); end
    stop = 1;
    cyc();
    n_tests++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL stop_run: got %0d, expected 3", state); end
    wait_state(3'd0, 200, ok);
    fault_in = 1; start = 1;
    cyc();
    n_tests++;
    if (state !== 3'd0 || fault_out !== 1'b0) begin n_fail++; $display("FAIL idle_fault_blocks_start: got st=%0d f=%b, expected st=0 f=0", state, fault_out); end
    fault_in = 0;
    cyc();
  endtask
  task automatic test_stop_warmup();
    bit seen2 = 0, saw1 = 0;
    int ndone = 0;
    target_level = 5; start = 1;
    cyc();
    for (int i = 0; i < 100 && !seen2; i++) begin cyc(); seen2 = speed_level == 4'd2; end
    stop = 1;
    cyc();
    n_tests++;
    if (!seen2 || state !== 3'd3 || speed_level !== 4'd2) begin n_fail++; $display("FAIL stop_warmup: got st=%0d lvl=%0d, expected st=3 lvl=2", state, speed_level); end
    start = 1;
    cyc();
    n_tests++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL start_in_cooldown: got %0d, expected 3", state); end
    for (int i = 0; i < 60; i++) begin
      cyc();
      n_tests++;
      if (dvec !== mvec()) begin n_fail++; $display("FAIL stop_trace@%0d: got %h, expected %h", i, dvec, mvec()); end
      if (state == 3'd3 && speed_level == 4'd1) saw1 = 1;
      if (session_done) ndone++;
    end
    n_tests++;
    if (!saw1 || ndone != 1 || state !== 3'd0) begin n_fail++; $display("FAIL stop_cooldown: got saw1=%0d done=%0d st=%0d, expected 1 1 0", saw1, ndone, state); end
  endtask
  task automatic test_reset_mid();
    bit ok;
    target_level = 3; start = 1;
    cyc();
    wait_state(3'd2, 200, ok);
    reset = 0;
    cyc();
    n_tests++;
    if (!ok || dvec !== 20'd0) begin n_fail++; $display("FAIL reset_mid_run: got %h, expected 0", dvec); end
    reset = 1;
    cyc();
    run_normal("rerun");
  endtask
  task automatic test_random();
    int nbad = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 399) != 0;
      start = $urandom_range(0, 7) == 0;
      stop = $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 119) == 0) fault_in = ~fault_in;
      fault_ack = $urandom_range(0, 3) == 0;
      adj_up = $urandom_range(0, 11) == 0;
      adj_down = $urandom_range(0, 11) == 0;
      target_level = 4'($urandom_range(0, 15));
      cyc();
      n_tests++;
      if (dvec !== mvec()) begin
        n_fail++;
        if (nbad++ < 20) $display("FAIL random@%0d: got %h, expected %h", i, dvec, mvec());
      end
    end
    fault_in = 0; reset = 1;
  endtask
  initial begin
    test_reset();
    run_normal("normal");
    test_clamp();
    test_fault();
    test_coincident();
    test_stop_warmup();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
